pico_ram_bridge: RTL
====================

// Module: pico_ram_bridge
// PURPOSE
//  Initiator side of the on-chip RAM: converts the PicoRV32 native memory bus (valid/ready) into the simple
//  dual-port RAM write/read ports (wren/wraddr/di, rden/rdaddr/do; read data registered, 1-cycle latency).
//  RAM has no byte enables, so partial-word stores are done as read-modify-write. Sits between CPU core and RAM.
// PARAMETERS
//  DWIDTH     32            data width; fixed at 32 (mem_wstrb is 4 bits)
//  AWIDTH     14            RAM word-address width (depth = 1<<AWIDTH words)
//  BASE_ADDR  32'h0000_0000 byte address mapped to RAM word 0
// PORTS
//  clk         in   1       single clock, all logic rising-edge
//  resetn      in   1       asynchronous, active-low reset
//  mem_valid   in   1       CPU request valid
//  mem_instr   in   1       instruction fetch flag (informational, does not change behaviour)
//  mem_addr    in   32      CPU byte address
//  mem_wdata   in   32      store data
//  mem_wstrb   in   4       byte strobes; 4'h0 = read
//  mem_ready   out  1       one-cycle completion pulse (registered)
//  mem_rdata   out  32      read data, valid when mem_ready=1 for reads (registered)
//  ram_wren    out  1       RAM write enable (registered)
//  ram_wraddr  out  AWIDTH  RAM write word address (registered)
//  ram_di      out  DWIDTH  RAM write data (registered)
//  ram_rden    out  1       RAM read enable (registered)
//  ram_rdaddr  out  AWIDTH  RAM read word address (registered)
//  ram_do      in   DWIDTH  RAM read data, valid 1 cycle after rden sampled
//  range_err   out  1       sticky out-of-range flag (tied 0 without PICO_RAM_RANGE_CHK_EN)
// BEHAVIOUR
//  - Reset: state IDLE; mem_ready, ram_wren, ram_rden, range_err = 0; mem_rdata, ram_di, addrs = 0.
//  - Word addr = (mem_addr - BASE_ADDR)[AWIDTH+1:2]; mem_addr[1:0] ignored.
//  - Cycle 0 = cycle IDLE sees mem_valid=1. Request fields latched at end of cycle 0.
//  - FSM: IDLE -> {RD_ISSUE | WR_ISSUE | RMW_RD} -> ... -> ACK -> IDLE.
//  - Read (wstrb=0): ram_rden=1 in cycle 1 only; cycle 2 (RD_WAIT) ram_do captured into mem_rdata;
//    mem_ready=1 in cycle 3. Latency 3.
//  - Full write (wstrb=4'hF): ram_wren=1, ram_di=wdata in cycle 1; mem_ready=1 in cycle 2.
//  - Partial write (wstrb not 0/F): ram_rden cycle 1; cycle 2 merge byte i = wstrb[i] ? wdata : ram_do;
//    ram_wren=1 with merged data cycle 3; mem_ready=1 cycle 4. rdaddr == wraddr throughout.
//  - mem_rdata unchanged by writes. ram_rden/ram_wren never both 1 in the same cycle.
//  - mem_valid ignored in ACK cycle; next request accepted earliest the cycle after mem_ready.
//  - mem_valid dropping mid-transaction (protocol violation): transaction still completes, ready still pulses.
//  - Reset mid-operation: immediate return to IDLE, pending RAM write suppressed, no mem_ready.
// CONFIGURATION
//  PICO_RAM_RANGE_CHK_EN defined: addresses outside [BASE_ADDR, BASE_ADDR+4*(1<<AWIDTH)) make no RAM
//    access; mem_ready=1 in cycle 1, mem_rdata=32'hDEAD_BEEF for reads; range_err set, sticky until reset.
//  Not defined: upper address bits ignored (aliasing wrap-around); range_err held 0.
// STRUCTURE
//  - Package pico_ram_pkg: FSM state enum, WSTRB_FULL=4'hF, RANGE_ERR_DATA=32'hDEAD_BEEF,
//    function byte_merge(wdata, rdata, wstrb).
//  - No sub-module; single flat FSM + datapath. Paired with the existing RAM macro in the SoC top.
// TESTING (bench: bridge + behavioural RAM, AWIDTH=14, BASE_ADDR=0)
//  - Read 0x40, RAM[0x10]=0x12345678 -> rden cycle 1, rdaddr=0x10; ready cycle 3, rdata=0x12345678.
//  - Store 0x44 wstrb=F wdata=0xCAFEF00D -> wren cycle 1, wraddr=0x11; ready cycle 2; RAM[0x11] updated.
//  - RAM[0x12]=0x12345678, store 0x48 wstrb=4'b0010 wdata=0xAABBCCDD -> wren cycle 3, di=0x1234CC78, ready cycle 4.
//  - Back-to-back read/write/read with valid held -> one ready pulse each, no overlap, rden&wren never both 1.
//  - resetn low in cycle 2 of partial write -> no wren ever asserted, RAM unchanged, no ready, FSM in IDLE.
//  - With PICO_RAM_RANGE_CHK_EN: read 0x0001_0000 -> no rden, ready cycle 1, rdata=0xDEADBEEF, range_err=1 held.

Source files
------------

// File: rtl/pico_ram_pkg.sv
// Shared types and constants for the PicoRV32-to-RAM bridge: FSM states,
// strobe/filler constants and the byte-lane merge used for partial stores.
package pico_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_RMW_RD,
        ST_RMW_MERGE,
        ST_RMW_WR,
        ST_ACK
    } state_t;

    localparam logic [3:0]  WSTRB_FULL     = 4'hF;
    localparam logic [31:0] RANGE_ERR_DATA = 32'hDEAD_BEEF;

    function automatic logic [31:0] byte_merge(input logic [31:0] wdata,
                                               input logic [31:0] rdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/pico_ram_bridge_if.sv
// PicoRV32 native memory bus (valid/ready handshake) between the CPU core
// (master) and the RAM bridge (slave).
interface pico_ram_bridge_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/pico_ram_bridge.sv
// PicoRV32 memory bus to simple dual-port RAM bridge; partial stores via read-modify-write.
// Optional address range checking enabled with `define PICO_RAM_RANGE_CHK_EN.
//
// state        | meaning
// ST_IDLE      | waiting for mem_valid, latches request fields
// ST_RD_ISSUE  | ram_rden high for a read
// ST_RD_WAIT   | ram_do valid, captured into mem_rdata
// ST_WR_ISSUE  | ram_wren high with full-word store data
// ST_RMW_RD    | ram_rden high for the old word of a partial store
// ST_RMW_MERGE | old word merged with store bytes
// ST_RMW_WR    | ram_wren high with merged word
// ST_ACK       | mem_ready pulse, mem_valid ignored
module pico_ram_bridge
    import pico_ram_pkg::*;
#(
    parameter int          DWIDTH    = 32,
    parameter int          AWIDTH    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    pico_ram_bridge_if.slave  bus,
    output logic              ram_wren,
    output logic [AWIDTH-1:0] ram_wraddr,
    output logic [DWIDTH-1:0] ram_di,
    output logic              ram_rden,
    output logic [AWIDTH-1:0] ram_rdaddr,
    input  logic [DWIDTH-1:0] ram_do,
    output logic              range_err
);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       off;
    logic [AWIDTH-1:0] word;
    logic              in_range;
    logic              accept;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              unused_bits;

    assign off         = bus.mem_addr - BASE_ADDR;
    assign word        = off[AWIDTH+1:2];
    assign accept      = (state == ST_IDLE) && bus.mem_valid;
    assign unused_bits = ^{bus.mem_instr, off};

`ifdef PICO_RAM_RANGE_CHK_EN
    // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both ends.
    assign in_range = ({1'b0, off} < (33'd1 << (AWIDTH + 2)));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) range_err <= 1'b0;
        else if (accept && !in_range) range_err <= 1'b1;
    end
`else
    assign in_range  = 1'b1;
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    if (!in_range)                     state_nxt = ST_ACK;
                    else if (bus.mem_wstrb == 4'h0)    state_nxt = ST_RD_ISSUE;
                    else if (bus.mem_wstrb == WSTRB_FULL) state_nxt = ST_WR_ISSUE;
                    else                               state_nxt = ST_RMW_RD;
                end
            end
            ST_RD_ISSUE:  state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:   state_nxt = ST_ACK;
            ST_WR_ISSUE:  state_nxt = ST_ACK;
            ST_RMW_RD:    state_nxt = ST_RMW_MERGE;
            ST_RMW_MERGE: state_nxt = ST_RMW_WR;
            ST_RMW_WR:    state_nxt = ST_ACK;
            ST_ACK:       state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            ram_wren      <= 1'b0;
            ram_rden      <= 1'b0;
            ram_wraddr    <= '0;
            ram_rdaddr    <= '0;
            ram_di        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            bus.mem_ready <= (state_nxt == ST_ACK);
            ram_rden      <= (state_nxt == ST_RD_ISSUE) || (state_nxt == ST_RMW_RD);
            ram_wren      <= (state_nxt == ST_WR_ISSUE) || (state_nxt == ST_RMW_WR);

            if (accept) begin
                ram_wraddr <= word;
                ram_rdaddr <= word;
                wdata_q    <= bus.mem_wdata;
                wstrb_q    <= bus.mem_wstrb;
                if (in_range && bus.mem_wstrb == WSTRB_FULL) ram_di <= bus.mem_wdata;
                if (!in_range && bus.mem_wstrb == 4'h0)      bus.mem_rdata <= RANGE_ERR_DATA;
            end

            if (state == ST_RD_WAIT)   bus.mem_rdata <= ram_do;
            if (state == ST_RMW_MERGE) ram_di <= byte_merge(wdata_q, ram_do, wstrb_q);
        end
    end

endmodule
